// File: rtl/serial_tcmp_n.sv
// Bit-serial, LSB-first two's complement negation on CHANNELS lanes that share one framing.
// Define TCMP_OVF_DETECT_EN to build the per-lane overflow flag for negating the most negative value.
module serial_tcmp_n #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [CHANNELS-1:0] in_bits,
    input  logic [CHANNELS-1:0] neg,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    output logic [CHANNELS-1:0] out_bits,
    output logic [CHANNELS-1:0] ovf
);

    localparam int unsigned   CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] z_q, z_d;
    logic [CHANNELS-1:0] n_q, n_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sof_q, out_sof_d;
    logic                out_eof_q, out_eof_d;
    logic [CHANNELS-1:0] out_bits_q, out_bits_d;

    logic                take_sof;
    logic                take_bit;
    logic                last_bit;
    logic [CNT_W-1:0]    bit_idx;

    // cnt_q is the index of the last accepted bit; bit_idx is the index of the bit now on the wire
    assign bit_idx  = cnt_q + CNT_W'(1);
    assign take_sof = in_valid & in_sof;
    assign take_bit = in_valid & ~in_sof & (state_q == ACTIVE);
    assign last_bit = take_bit & (bit_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            z_q         <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_bits_q  <= out_bits_d;
        end
    end

    // A sof always restarts framing, abandoning any word in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (take_sof) begin
            state_d = ACTIVE;
            cnt_d   = '0;
        end else if (take_bit) begin
            cnt_d = bit_idx;
            if (bit_idx == LAST_IDX) begin
                state_d = IDLE;
            end
        end
    end

    // Serial negate: copy bits up to and including the first one, invert every bit after it
    always_comb begin
        z_d         = z_q;
        n_d         = n_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_bits_d  = '0;
        if (take_sof) begin
            z_d         = in_bits;
            n_d         = neg;
            out_valid_d = 1'b1;
            out_sof_d   = 1'b1;
            out_bits_d  = in_bits;
        end else if (take_bit) begin
            z_d         = z_q | in_bits;
            out_valid_d = 1'b1;
            out_eof_d   = last_bit;
            out_bits_d  = in_bits ^ (n_q & z_q);
        end
    end

`ifdef TCMP_OVF_DETECT_EN
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    // Only -2^(WORD_W-1) arrives at the MSB as a one with no earlier one seen
    always_comb begin
        ovf_d = '0;
        if (last_bit) begin
            ovf_d = n_q & in_bits & ~z_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_bits  = out_bits_q;

endmodule
